seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a bank of 7-segment digits sharing one BCD decoder.

---
 rtl/seg_scan_ctrl.sv | 89 ++++++++
 tb/tb_seg_scan_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for multiplexed 7-segment digits sharing one BCD decoder.
// Display values are double-buffered. They commit only at frame boundaries, so a frame never shows a mix of old and new digits.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int BLANK      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic                    lz_en,
    output logic [3:0]              Q,
    output logic                    blank,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int TICK_W = $clog2(DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [TICK_W-1:0]       tick;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] disp;
    logic                    pending;

    logic                    last_tick;
    logic                    boundary;
    logic                    in_blank;
    logic [NUM_DIGITS-1:0]   supp;

    assign last_tick = (tick == TICK_W'(DIV - 1));
    assign boundary  = last_tick && (idx == IDX_W'(NUM_DIGITS - 1));
    assign in_blank  = (tick < TICK_W'(BLANK));

    // Walk from the most significant digit downwards. A digit is a leading zero
    // only while every digit above it (and the digit itself) is zero.
    always_comb begin : supp_calc
        logic zero_run;
        supp     = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp[4*i +: 4] == 4'd0);
            supp[i]  = (disp[4*i +: 4] > 4'd9) || (lz_en && (i != 0) && zero_run);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick       <= '0;
            idx        <= '0;
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            Q          <= 4'd0;
            blank      <= 1'b1;
            dig_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (last_tick) begin
                tick <= '0;
                idx  <= boundary ? '0 : idx + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end

            Q          <= disp[{idx, 2'b00} +: 4];
            blank      <= in_blank ? 1'b1 : supp[idx];
            dig_sel    <= in_blank ? '0 : (NUM_DIGITS'(1) << idx);
            frame_done <= boundary;

            // A load that lands on the boundary bypasses the shadow so no frame is lost.
            if (load) begin
                shadow <= din;
                if (boundary) begin
                    disp    <= din;
                    pending <= 1'b0;
                end else begin
                    pending <= 1'b1;
                end
            end else if (boundary && pending) begin
                disp    <= shadow;
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DIV=8, BLANK=2.
// Each frame is 32 cycles; digit slots are 8 cycles, and the first 2 cycles of each slot are blanked.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] din;
    logic        lz_en;
    logic [3:0]  Q;
    logic        blank;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    seg_scan_ctrl #(.NUM_DIGITS(4), .DIV(8), .BLANK(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .din        (din),
        .lz_en      (lz_en),
        .Q          (Q),
        .blank      (blank),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock: drive load/din, step past the edge, and check the one-hot invariant.
    task automatic applyStimulus(input logic ld, input logic [15:0] d);
        load = ld;
        if (ld) din = d;
        @(posedge clk);
        #1;
        load = 1'b0;
        checkOutput("onehot", 32'($countones(dig_sel) > 1), 32'd0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_q"},     32'(Q),          32'd0);
        checkOutput({tag, "_blank"}, 32'(blank),      32'd1);
        checkOutput({tag, "_sel"},   32'(dig_sel),    32'd0);
        checkOutput({tag, "_fd"},    32'(frame_done), 32'd0);
    endtask

    // Runs one full frame starting at tick=0, idx=0, with up to two optional loads at edges la1 and la2 (1..32).
    task automatic checkFrame(input logic [15:0] exp_disp, input logic [3:0] exp_blank,
                              input int la1, input logic [15:0] lv1,
                              input int la2, input logic [15:0] lv2);
        int slot;
        int tk;
        for (int k = 1; k <= 32; k++) begin
            if (k == la1)      applyStimulus(1'b1, lv1);
            else if (k == la2) applyStimulus(1'b1, lv2);
            else               applyStimulus(1'b0, 16'h0);
            slot = (k - 1) / 8;
            tk   = (k - 1) % 8;
            checkOutput("q", 32'(Q), 32'(exp_disp[slot*4 +: 4]));
            checkOutput("fd", 32'(frame_done), 32'(k == 32));
            if (tk < 2) begin
                checkOutput("gap_sel", 32'(dig_sel), 32'd0);
                checkOutput("gap_blank", 32'(blank), 32'd1);
            end else begin
                checkOutput("drv_sel", 32'(dig_sel), 32'(4'b0001 << slot));
                checkOutput("drv_blank", 32'(blank), 32'(exp_blank[slot]));
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        din   = 16'h0;
        lz_en = 1'b0;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h0);
            checkReset("rst_hold");
        end
        rst = 1'b0;

        // Zero display; a mid-frame load must not disturb this frame.
        checkFrame(16'h0000, 4'b0000, 11, 16'h1234, 0, 16'h0);
        checkFrame(16'h1234, 4'b0000, 0, 16'h0, 0, 16'h0);

        // Leading-zero suppression.
        lz_en = 1'b1;
        checkFrame(16'h1234, 4'b0000, 5, 16'h0050, 0, 16'h0);
        checkFrame(16'h0050, 4'b1100, 5, 16'h00A0, 0, 16'h0);
        lz_en = 1'b0;

        // Invalid code, then last-load-wins within a frame.
        checkFrame(16'h00A0, 4'b0010, 3, 16'h1111, 20, 16'h2222);
        // A load on the boundary cycle bypasses straight into the next frame.
        checkFrame(16'h2222, 4'b0000, 32, 16'h3333, 0, 16'h0);
        checkFrame(16'h3333, 4'b0000, 0, 16'h0, 0, 16'h0);

        // Mid-frame reset with a pending load.
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(k == 5, 16'h4444);
            checkOutput("pre_rst_q", 32'(Q), 32'd3);
        end
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0);
        checkReset("mid_rst");
        rst = 1'b0;
        checkFrame(16'h0000, 4'b0000, 0, 16'h0, 0, 16'h0);
        checkFrame(16'h0000, 4'b0000, 0, 16'h0, 0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
